// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory-unit port between requester 0 (CPU datapath)
//   and requester 1 (DMA / debug master). Round-robin on contention, a
//   bounded lock for atomic sequences, one access per clock, fixed 2-edge
//   completion latency.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   req_/addr_/wdata_/we_/lock_{0,1}   requester inputs (held while req && !gnt)
//   gnt_{0,1}                combinational grant
//   rvalid_{0,1}, rdata_{0,1} completion pulse and read data per requester
//   lock_abort               one-cycle pulse when a lock times out
//   mem_addr/mem_wdata/mem_we  registered drive to the memory unit
//   mem_rdata                read data from the memory unit
module mem_port_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              we_0,
    input  logic              lock_0,
    input  logic              req_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              we_1,
    input  logic              lock_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              lock_abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {UNLOCKED, LOCKED_0, LOCKED_1} state_t;

    state_t             state, state_nxt;
    logic               last_grant, last_grant_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic               abort_nxt;

    // issue stage: access presented to memory this cycle, and its owner
    logic               iss_vld;
    logic               iss_own;

    logic               acc_0, acc_1, acc, sel;
    logic               sel_lock, sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               timeout;

    // Grant depends only on req, state and last_grant.
    // last_grant == 1 means requester 0 wins the next conflict.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        case (state)
            LOCKED_0: gnt_0 = req_0;
            LOCKED_1: gnt_1 = req_1;
            default: begin
                if (req_0 && req_1) begin
                    gnt_0 = last_grant;
                    gnt_1 = ~last_grant;
                end else begin
                    gnt_0 = req_0;
                    gnt_1 = req_1;
                end
            end
        endcase
    end

    assign acc_0     = req_0 & gnt_0;
    assign acc_1     = req_1 & gnt_1;
    assign acc       = acc_0 | acc_1;
    assign sel       = acc_1;
    assign sel_lock  = sel ? lock_1  : lock_0;
    assign sel_we    = sel ? we_1    : we_0;
    assign sel_addr  = sel ? addr_1  : addr_0;
    assign sel_wdata = sel ? wdata_1 : wdata_0;
    assign timeout   = (lock_cnt == CNT_W'(MAX_LOCK));

    always_comb begin
        state_nxt      = state;
        lock_cnt_nxt   = lock_cnt;
        last_grant_nxt = acc ? sel : last_grant;
        abort_nxt      = 1'b0;
        case (state)
            UNLOCKED: begin
                lock_cnt_nxt = '0;
                if (acc && sel_lock) begin
                    state_nxt    = sel ? LOCKED_1 : LOCKED_0;
                    lock_cnt_nxt = CNT_W'(1);
                end
            end
            LOCKED_0, LOCKED_1: begin
                // only the owner can be accepting here, so acc implies owner
                if (acc && !sel_lock) begin
                    state_nxt    = UNLOCKED;
                    lock_cnt_nxt = '0;
                end else if (timeout) begin
                    // a locked accept on this edge still goes to memory
                    state_nxt      = UNLOCKED;
                    lock_cnt_nxt   = '0;
                    abort_nxt      = 1'b1;
                    last_grant_nxt = (state == LOCKED_1);
                end else begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= UNLOCKED;
            last_grant <= 1'b1;
            lock_cnt   <= '0;
            lock_abort <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            iss_vld    <= 1'b0;
            iss_own    <= 1'b0;
            rvalid_0   <= 1'b0;
            rvalid_1   <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            lock_cnt   <= lock_cnt_nxt;
            lock_abort <= abort_nxt;
            if (acc) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            mem_we   <= acc & sel_we;
            iss_vld  <= acc;
            iss_own  <= sel;
            // memory captures read data on the edge after issue
            rvalid_0 <= iss_vld & ~iss_own;
            rvalid_1 <= iss_vld & iss_own;
        end
    end

    assign rdata_0 = mem_rdata;
    assign rdata_1 = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory unit, a transaction-level
// reference model, a vector table, directed corner sequences and random
// traffic.
module tb_mem_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_0, req_1, we_0, we_1, lock_0, lock_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1, lock_abort, mem_we;
    logic [DW-1:0] rdata_0, rdata_1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .addr_0(addr_0), .wdata_0(wdata_0), .we_0(we_0), .lock_0(lock_0),
        .req_1(req_1), .addr_1(addr_1), .wdata_1(wdata_1), .we_1(we_1), .lock_1(lock_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1), .lock_abort(lock_abort),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // memory unit: read on rising edge, write on falling edge
    logic [DW-1:0] umem [0:2047];
    always @(posedge clk) mem_rdata <= umem[mem_addr];
    always @(negedge clk) if (mem_we) umem[mem_addr] <= mem_wdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {bit v; int own; bit rd; logic [DW-1:0] d;} slot_t;
    logic [DW-1:0] ref_mem [0:2047];
    int            m_owner;   // -1: nobody holds a lock
    int            m_last;    // requester granted most recently
    int            m_age;     // cycles the current lock has been held
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_we, m_abort;
    slot_t         p_iss, p_out;  // accepted one edge ago / completing now
    bit            g0_s, g1_s;

    function automatic void model_reset();
        m_owner = -1; m_last = 1; m_age = 0;
        m_addr = '0; m_wdata = '0; m_we = 0; m_abort = 0;
        p_iss = '{0, 0, 0, '0}; p_out = '{0, 0, 0, '0};
    endfunction

    function automatic void model_grant(input bit r0, input bit r1, output bit e0, output bit e1);
        if (m_owner == 0)      begin e0 = r0; e1 = 0; end
        else if (m_owner == 1) begin e0 = 0;  e1 = r1; end
        else if (r0 && r1)     begin e0 = (m_last == 1); e1 = !e0; end
        else                   begin e0 = r0; e1 = r1; end
    endfunction

    function automatic void model_edge(input bit r0, r1, l0, l1, w0, w1,
                                       input logic [AW-1:0] a0, a1,
                                       input logic [DW-1:0] d0, d1, input bit e0, e1);
        bit acc, lk, we;
        int who;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        acc = (r0 && e0) || (r1 && e1);
        who = (r1 && e1) ? 1 : 0;
        lk  = who ? l1 : l0;
        we  = who ? w1 : w0;
        a   = who ? a1 : a0;
        d   = who ? d1 : d0;
        m_abort = 0;
        p_out = p_iss;
        p_iss = '{acc, who, !we, ref_mem[a]};
        if (acc) begin
            if (we) ref_mem[a] = d;
            m_addr = a; m_wdata = d; m_last = who;
        end
        m_we = acc && we;
        if (m_owner < 0) begin
            if (acc && lk) begin m_owner = who; m_age = 1; end
        end else if (acc && !lk) begin
            m_owner = -1;
        end else if (m_age == ML) begin
            m_last = m_owner; m_owner = -1; m_abort = 1;
        end else begin
            m_age++;
        end
    endfunction

    // one clock: drive, check grants at negedge, check registered outputs after edge
    task automatic step(input bit r0, r1, l0, l1, w0, w1,
                        input logic [AW-1:0] a0, a1, input logic [DW-1:0] d0, d1);
        bit e0, e1;
        req_0 = r0; lock_0 = l0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
        req_1 = r1; lock_1 = l1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
        @(negedge clk);
        g0_s = gnt_0; g1_s = gnt_1;
        model_grant(r0, r1, e0, e1);
        chk("gnt_0", g0_s, e0);
        chk("gnt_1", g1_s, e1);
        @(posedge clk);
        model_edge(r0, r1, l0, l1, w0, w1, a0, a1, d0, d1, e0, e1);
        #1;
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_we", mem_we, m_we);
        chk("lock_abort", lock_abort, m_abort);
        chk("rvalid_0", rvalid_0, p_out.v && p_out.own == 0);
        chk("rvalid_1", rvalid_1, p_out.v && p_out.own == 1);
        if (p_out.v && p_out.rd)
            chk(p_out.own == 0 ? "rdata_0" : "rdata_1",
                p_out.own == 0 ? rdata_0 : rdata_1, p_out.d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1;
        req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0; we_0 = 0; we_1 = 0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    typedef struct {bit r0, r1, l0, l1, w1, e0, e1;} vec_t;
    vec_t tbl [11];

    initial begin
        bit r0, r1, l0, l1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;

        //              r0 r1 l0 l1 w1 g0 g1
        tbl[0]  = '{1, 1, 0, 0, 0, 1, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0, 1};
        tbl[2]  = '{1, 1, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0, 1};
        tbl[4]  = '{0, 1, 0, 0, 1, 0, 1};
        tbl[5]  = '{1, 1, 0, 0, 0, 1, 0};
        tbl[6]  = '{1, 1, 1, 0, 0, 0, 1};
        tbl[7]  = '{1, 1, 1, 0, 0, 1, 0};
        tbl[8]  = '{1, 1, 0, 0, 0, 1, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 2048; i++) begin
            umem[i] = 16'(i * 7 + 3);
            ref_mem[i] = umem[i];
        end
        umem[16'h010] = 16'h1234;
        ref_mem[16'h010] = 16'h1234;

        // reset state
        do_reset();
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid_0", rvalid_0, 0);
        chk("rst_rvalid_1", rvalid_1, 0);
        chk("rst_lock_abort", lock_abort, 0);
        chk("rst_gnt_0", gnt_0, 0);

        // single read by requester 0
        step(1, 0, 0, 0, 0, 0, 11'h010, '0, '0, '0);
        chk("t1_gnt_0", g0_s, 1);
        chk("t1_mem_addr", mem_addr, 11'h010);
        chk("t1_mem_we", mem_we, 0);
        step(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        chk("t1_rvalid_0", rvalid_0, 1);
        chk("t1_rdata_0", rdata_0, 16'h1234);

        // requester 1 locked write then unlocked read while requester 0 waits
        step(1, 1, 0, 1, 0, 1, 11'h030, 11'h204, '0, 16'h0005);
        chk("t3_gnt_0_a", g0_s, 0);
        chk("t3_gnt_1_a", g1_s, 1);
        step(1, 1, 0, 0, 0, 0, 11'h030, 11'h203, '0, '0);
        chk("t3_gnt_0_b", g0_s, 0);
        chk("t3_gnt_1_b", g1_s, 1);
        chk("t3_abort_b", lock_abort, 0);
        step(1, 0, 0, 0, 0, 0, 11'h204, '0, '0, '0);
        chk("t3_gnt_0_c", g0_s, 1);
        chk("t3_abort_c", lock_abort, 0);
        step(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        chk("t3_rdata_204", rdata_0, 16'h0005);
        idle(1);

        // lock timeout with requester 1 waiting
        step(1, 0, 1, 0, 0, 0, 11'h040, '0, '0, '0);
        for (int k = 1; k <= ML; k++) begin
            step(0, 1, 0, 0, 0, 0, '0, 11'h140, '0, '0);
            chk("t4_gnt_1_locked", g1_s, 0);
        end
        chk("t4_abort_pulse", lock_abort, 1);
        step(0, 1, 0, 0, 0, 0, '0, 11'h140, '0, '0);
        chk("t4_gnt_1_after", g1_s, 1);
        chk("t4_abort_once", lock_abort, 0);
        idle(2);

        // release on the same edge the lock would time out
        step(1, 0, 1, 0, 0, 0, 11'h050, '0, '0, '0);
        idle(ML - 1);
        step(1, 0, 0, 0, 0, 0, 11'h051, '0, '0, '0);
        chk("t5_gnt_0", g0_s, 1);
        chk("t5_no_abort", lock_abort, 0);
        step(1, 1, 0, 0, 0, 0, 11'h052, 11'h152, '0, '0);
        chk("t5_unlocked_gnt_1", g1_s, 1);
        chk("t5_no_abort_2", lock_abort, 0);
        idle(2);

        // vector table from reset: round-robin and lock hand-off
        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, 0, tbl[i].w1,
                 11'h020, 11'h120, 16'hA5A5, 16'h5A5A);
            chk($sformatf("tbl%0d_gnt_0", i), g0_s, tbl[i].e0);
            chk($sformatf("tbl%0d_gnt_1", i), g1_s, tbl[i].e1);
        end
        idle(2);

        // reset in the middle of a locked read
        step(1, 0, 1, 0, 0, 0, 11'h060, '0, '0, '0);
        #2;
        reset = 1;
        req_0 = 0; req_1 = 0; lock_0 = 0;
        #1;
        chk("t6_mem_we", mem_we, 0);
        chk("t6_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        chk("t6_no_rvalid_0", rvalid_0, 0);
        chk("t6_no_rvalid_1", rvalid_1, 0);
        reset = 0;
        model_reset();
        step(1, 1, 0, 0, 0, 0, 11'h061, 11'h161, '0, '0);
        chk("t6_first_conflict_0", g0_s, 1);
        chk("t6_first_conflict_1", g1_s, 0);
        step(0, 1, 0, 0, 0, 0, '0, 11'h162, '0, '0);
        chk("t6_unlocked", g1_s, 1);
        idle(2);

        // random traffic against the model
        r0 = 0; r1 = 0; l0 = 0; l1 = 0; w0 = 0; w1 = 0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int n = 0; n < 600; n++) begin
            if (!(r0 && !g0_s)) begin
                r0 = 1'($urandom_range(0, 1));
                l0 = ($urandom_range(0, 3) == 0);
                w0 = 1'($urandom_range(0, 1));
                a0 = 11'($urandom_range(0, 15)) + ($urandom_range(0, 1) ? 11'h200 : 11'h000);
                d0 = 16'($urandom);
            end
            if (!(r1 && !g1_s)) begin
                r1 = 1'($urandom_range(0, 1));
                l1 = ($urandom_range(0, 3) == 0);
                w1 = 1'($urandom_range(0, 1));
                a1 = 11'($urandom_range(0, 15)) + ($urandom_range(0, 1) ? 11'h200 : 11'h000);
                d1 = 16'($urandom);
            end
            step(r0, r1, l0, l1, w0, w1, a0, a1, d0, d1);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
